// File: rtl/fetch_stage_f.sv
// F-stage of the 5-stage MIPS pipeline: the PC register, instruction-memory addressing,
// next-PC selection (beq / j / jr targets) and the F/D pipeline register.
module fetch_stage_f #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_AW    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             fd_clr,
  input  logic             pc_sel,
  input  logic [1:0]       npc_sel,
  input  logic [31:0]      rs_data_d,
  input  logic [31:0]      instr_f,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      pc_f,
  output logic [31:0]      instr_d,
  output logic [31:0]      pc_d,
  output logic [31:0]      pc8_d
);

  localparam logic [31:0]      NOP     = 32'h0000_0000;
  // The IM base is word aligned, so the word-address subtraction never borrows from bits [1:0].
  localparam logic [IM_AW-1:0] IM_BASE = PC_RESET[IM_AW+1:2];

  localparam logic [1:0] NPC_BEQ = 2'b00;
  localparam logic [1:0] NPC_J   = 2'b01;
  localparam logic [1:0] NPC_JR  = 2'b10;

  logic [31:0] pc_f_q,    pc_f_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pc_d_q,    pc_d_d;

  logic [31:0] pc4_f;
  logic [31:0] pc4_d;
  logic [31:0] br_off;
  logic [31:0] beq_tgt;
  logic [31:0] j_tgt;
  logic [31:0] target;
  logic [31:0] next_pc;

  assign pc4_f   = pc_f_q + 32'd4;
  assign pc4_d   = pc_d_q + 32'd4;
  assign br_off  = {{14{instr_d_q[15]}}, instr_d_q[15:0], 2'b00};
  assign beq_tgt = pc4_d + br_off;
  assign j_tgt   = {pc4_d[31:28], instr_d_q[25:0], 2'b00};

  always_comb begin
    target = pc4_f;
    case (npc_sel)
      NPC_BEQ: target = beq_tgt;
      NPC_J:   target = j_tgt;
      NPC_JR:  target = rs_data_d;
      default: target = pc4_f;
    endcase
  end

  assign next_pc = pc_sel ? target : pc4_f;

  // Stall freezes everything and overrides both the bubble request and the redirect.
  always_comb begin
    pc_f_d    = pc_f_q;
    instr_d_d = instr_d_q;
    pc_d_d    = pc_d_q;
    if (!stall) begin
      pc_f_d    = next_pc;
      instr_d_d = fd_clr ? NOP : instr_f;
      pc_d_d    = pc_f_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f_q    <= PC_RESET;
      instr_d_q <= NOP;
      pc_d_q    <= PC_RESET;
    end else begin
      pc_f_q    <= pc_f_d;
      instr_d_q <= instr_d_d;
      pc_d_q    <= pc_d_d;
    end
  end

  assign im_addr = pc_f_q[IM_AW+1:2] - IM_BASE;
  assign pc_f    = pc_f_q;
  assign instr_d = instr_d_q;
  assign pc_d    = pc_d_q;
  assign pc8_d   = pc_d_q + 32'd8;

endmodule

// File: tb/tb_fetch_stage_f.sv
// Scoreboard bench for fetch_stage_f: stimulus pushes cycle-tagged expected state,
// a negedge monitor pops and compares every DUT output.
module tb_fetch_stage_f;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        fd_clr;
  logic        pc_sel;
  logic [1:0]  npc_sel;
  logic [31:0] rs_data_d;
  logic [31:0] instr_f;
  logic [11:0] im_addr;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;

  fetch_stage_f #(.PC_RESET(32'h0000_3000), .IM_AW(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .fd_clr    (fd_clr),
    .pc_sel    (pc_sel),
    .npc_sel   (npc_sel),
    .rs_data_d (rs_data_d),
    .instr_f   (instr_f),
    .im_addr   (im_addr),
    .pc_f      (pc_f),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pc8_d     (pc8_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s got=%h expected=%h", nm, fld, act, expv);
    end
  endtask

  exp_t        e;
  logic [31:0] off;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s stale entry tag=%0d now=%0d", e.name, e.cyc, cyc);
      end else begin
        off = e.pc_f - 32'h0000_3000;
        $display("txn %-12s pc_f=%h instr_d=%h pc_d=%h im_addr=%h pc8_d=%h",
                 e.name, pc_f, instr_d, pc_d, im_addr, pc8_d);
        chk(e.name, "pc_f",    pc_f,           e.pc_f);
        chk(e.name, "instr_d", instr_d,        e.instr_d);
        chk(e.name, "pc_d",    pc_d,           e.pc_d);
        chk(e.name, "im_addr", {20'h0, im_addr}, {20'h0, off[13:2]});
        chk(e.name, "pc8_d",   pc8_d,          e.pc_d + 32'd8);
      end
    end
  end

  task automatic drive(input logic st, input logic clr, input logic sel, input logic [1:0] ns,
                       input logic [31:0] rs, input logic [31:0] ins);
    stall = st; fd_clr = clr; pc_sel = sel; npc_sel = ns; rs_data_d = rs; instr_f = ins;
  endtask

  // Expected state after the coming rising edge.
  task automatic push_exp(input string nm, input logic [31:0] p, input logic [31:0] i, input logic [31:0] pd);
    q.push_back('{cyc + 1, nm, p, i, pd});
  endtask

  task automatic step(input string nm, input logic st, input logic clr, input logic sel,
                      input logic [1:0] ns, input logic [31:0] rs, input logic [31:0] ins,
                      input logic [31:0] p, input logic [31:0] i, input logic [31:0] pd);
    @(negedge clk);
    #1;
    drive(st, clr, sel, ns, rs, ins);
    push_exp(nm, p, i, pd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 2'b10, 32'h1234_5678, 32'hDEAD_BEEF);
    // Reset held across edges with redirecting inputs: state must stay at reset values.
    step("rst_hold0", 1'b0, 1'b0, 1'b1, 2'b10, 32'h1234_5678, 32'hDEAD_BEEF, 32'h3000, 32'h0, 32'h3000);
    step("rst_hold1", 1'b0, 1'b0, 1'b1, 2'b10, 32'h1234_5678, 32'hDEAD_BEEF, 32'h3000, 32'h0, 32'h3000);

    @(negedge clk);
    #1;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h1111_0000);
    push_exp("run_3004", 32'h3004, 32'h1111_0000, 32'h3000);
    step("run_3008", 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h1111_0001, 32'h3008, 32'h1111_0001, 32'h3004);
    step("run_300C", 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h1111_0002, 32'h300C, 32'h1111_0002, 32'h3008);
    step("run_3010", 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h1111_0003, 32'h3010, 32'h1111_0003, 32'h300C);

    // beq at 0x3010 with offset -2 words: target 0x300C, slot from 0x3014 still enters D.
    step("fetch_beq",  1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h1000_FFFE, 32'h3014, 32'h1000_FFFE, 32'h3010);
    step("beq_taken",  1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h2222_0001, 32'h300C, 32'h2222_0001, 32'h3014);
    step("run_3010b",  1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h1111_0004, 32'h3010, 32'h1111_0004, 32'h300C);
    step("run_3014",   1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h1111_0005, 32'h3014, 32'h1111_0005, 32'h3010);
    step("run_3018",   1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h1111_0006, 32'h3018, 32'h1111_0006, 32'h3014);
    step("run_301C",   1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h1111_0007, 32'h301C, 32'h1111_0007, 32'h3018);
    step("run_3020",   1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h1111_0008, 32'h3020, 32'h1111_0008, 32'h301C);

    // jal at 0x3020, index 0xC10 -> 0x3040; link value 0x3028 while in D.
    step("fetch_jal",  1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0C00_0C10, 32'h3024, 32'h0C00_0C10, 32'h3020);
    step("jal_taken",  1'b0, 1'b0, 1'b1, 2'b01, 32'h0, 32'h2222_0002, 32'h3040, 32'h2222_0002, 32'h3024);

    step("fetch_jr",   1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h03E0_0008, 32'h3044, 32'h03E0_0008, 32'h3040);
    step("jr_taken",   1'b0, 1'b0, 1'b1, 2'b10, 32'h0000_3100, 32'h2222_0003, 32'h3100, 32'h2222_0003, 32'h3044);
    step("npc_rsvd",   1'b0, 1'b0, 1'b1, 2'b11, 32'h5555_0000, 32'h1111_0009, 32'h3104, 32'h1111_0009, 32'h3100);

    // beq (+4 words) held in D by a 2-cycle stall with fd_clr and pc_sel active.
    step("fetch_beq2", 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h1000_0004, 32'h3108, 32'h1000_0004, 32'h3104);
    step("stall0",     1'b1, 1'b1, 1'b1, 2'b00, 32'h0, 32'hBAD0_0000, 32'h3108, 32'h1000_0004, 32'h3104);
    step("stall1",     1'b1, 1'b1, 1'b1, 2'b00, 32'h0, 32'hBAD0_0001, 32'h3108, 32'h1000_0004, 32'h3104);
    step("beq2_taken", 1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h2222_0004, 32'h3118, 32'h2222_0004, 32'h3108);
    step("after_beq2", 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h1111_000A, 32'h311C, 32'h1111_000A, 32'h3118);
    step("fd_clr",     1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h1111_000B, 32'h3120, 32'h0,         32'h311C);

    // PC wraparound and im_addr aliasing for out-of-range PCs.
    step("jr_top",     1'b0, 1'b0, 1'b1, 2'b10, 32'hFFFF_FFFC, 32'h1111_000C, 32'hFFFF_FFFC, 32'h1111_000C, 32'h3120);
    step("wrap",       1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h1111_000D, 32'h0000_0000, 32'h1111_000D, 32'hFFFF_FFFC);

    // Asynchronous reset between edges: visible before any further rising edge.
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    q.push_back('{cyc, "async_rst", 32'h3000, 32'h0, 32'h3000});
    @(negedge clk);
    #1;
    push_exp("rst_hold2", 32'h3000, 32'h0, 32'h3000);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain queue left=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage_f.md
Name: fetch_stage_f

Overview:
- F-stage of the 5-stage MIPS pipeline: holds the PC, addresses the instruction memory, computes the next PC, and owns the F/D pipeline register.
- Consumes pc_sel and npc_sel produced by the D-stage controller, plus the forwarded GPR[rs] for jr.
- Produces instr_d, pc_d and pc8_d, which drive the D-stage controller, the comparator, EXT and the link-value path.
- Architectural delay slot: a taken branch or jump never squashes the slot instruction.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset; also the IM base address.
- IM_AW, 12, IM word-address width; IM holds 4096 words.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; 0 = in reset
- stall  input  1  from hazard unit; freezes PC and the F/D register
- fd_clr  input  1  load a nop bubble into the F/D register (reserved for later stages)
- pc_sel  input  1  0 = next PC is pc_f+4; 1 = next PC is the npc_sel target
- npc_sel  input  2  00 beq target, 01 j/jal target, 10 jr target, 11 reserved
- rs_data_d  input  32  forwarded GPR[rs] in D, used as the jr target
- instr_f  input  32  IM read data; combinational, valid in the same cycle as im_addr
- im_addr  output  IM_AW  word address sent to IM
- pc_f  output  32  current fetch PC
- instr_d  output  32  F/D register: instruction
- pc_d  output  32  F/D register: PC of instr_d
- pc8_d  output  32  pc_d+8, the jal link value

Behaviour:
- Reset (reset=0, asynchronous, regardless of clk):
  - pc_f = PC_RESET
  - instr_d = 32'h0
  - pc_d = PC_RESET
  - Outputs hold these values until the first rising edge after reset deasserts.
- Reset asserted mid-operation takes effect immediately; no partial update may be left behind.
- im_addr = (pc_f - PC_RESET)[IM_AW+1:2]. Purely combinational. Upper bits are dropped, so out-of-range PCs alias.
- Target computation (combinational, all arithmetic mod 2^32):
  - beq = pc_d + 4 + (sign_extend(instr_d[15:0]) << 2)
  - j/jal = {pc_d[31:28] + carry-free from pc_d+4, i.e. (pc_d+4)[31:28], instr_d[25:0], 2'b00}
  - jr = rs_data_d, used unmodified; no alignment check or exception
  - npc_sel=11 selects pc_f+4
- next_pc = pc_sel ? target : pc_f+4. pc_f+4 wraps: 32'hFFFF_FFFC goes to 32'h0000_0000.
- Rising edge with stall=0 and fd_clr=0: pc_f <= next_pc; instr_d <= instr_f; pc_d <= pc_f. Single-cycle latency from fetch to D.
- Rising edge with stall=0 and fd_clr=1: pc_f <= next_pc; instr_d <= 32'h0 (nop); pc_d <= pc_f.
- Rising edge with stall=1: pc_f, instr_d and pc_d all hold.
  - stall overrides both fd_clr and pc_sel.
  - A branch held in D is re-evaluated on the next unstalled cycle using the new forwarded rs_data_d.
- Delay slot: when pc_sel=1 for a jump/branch in D, the instruction in F is the delay slot. It enters D normally on the same edge that loads the target into pc_f.
- pc8_d = pc_d + 8, combinational, mod 2^32.
- No other state. Only two register groups exist: the PC register and the F/D register.

Test Plan:
- Reset, then release with 3 free-running cycles → pc_f goes 0x3000, 0x3004, 0x3008, 0x300C. im_addr goes 0, 1, 2, 3. pc_d lags pc_f by exactly one cycle.
- beq in D at pc_d=0x3010 with imm16=0xFFFE, pc_sel=1, npc_sel=00 → next pc_f=0x300C. The delay-slot instruction fetched at 0x3014 appears in instr_d with pc_d=0x3014.
- jal in D at pc_d=0x3020 with index=26'h0000C10, pc_sel=1, npc_sel=01 → pc_f=0x0000_3040 and pc8_d=0x3028 while the jal is in D.
- jr with rs_data_d=0x0000_3100, pc_sel=1, npc_sel=10 → pc_f=0x3100. Repeat with npc_sel=11 → pc_f=pc_f+4.
- stall=1 for 2 cycles while a beq sits in D and fd_clr=1 → pc_f, instr_d and pc_d are all unchanged. On release, the branch is taken once.
- Force pc_f=0xFFFF_FFFC via jr, then run 1 cycle with pc_sel=0 → pc_f=0x0000_0000. Assert reset asynchronously between clock edges → pc_f becomes 0x3000 and instr_d becomes 0 immediately.
